frame_buffer_arbiter: RTL and testbench
=======================================

Name: frame_buffer_arbiter

Overview:
- Owns the single read/write port of the 800x480 pixel frame buffer.
- Shares that port between two requesters:
  - display pixel fetch, driven by the scan position generator's next_x/next_y;
  - draw-engine pixel writes.
- Display fetch has strict priority. Writes are buffered in a small FIFO and drained in any cycle the display leaves the port idle, which includes blanking.
- Converts (x, y) to a linear address.

Parameters:
- SCREEN_WIDTH, 800, visible pixels per line.
- SCREEN_HEIGHT, 480, visible lines.
- DATA_WIDTH, 16, pixel width in bits.
- ADDR_WIDTH, 19, frame buffer address width. Must satisfy 2^ADDR_WIDTH >= SCREEN_WIDTH*SCREEN_HEIGHT.
- WR_FIFO_DEPTH, 4, write FIFO entries, power of two, >= 2.
- MEM_LATENCY, 1, cycles from mem_addr to valid mem_rdata, >= 1.

Ports:
- clock  input  1  system clock, single domain.
- reset_n  input  1  asynchronous active-low reset.
- disp_req  input  1  display fetch request this cycle.
- disp_x  input  16  fetch column.
- disp_y  input  16  fetch row.
- disp_valid  output  1  fetched pixel valid.
- disp_data  output  DATA_WIDTH  fetched pixel.
- wr_valid  input  1  draw write offered.
- wr_ready  output  1  write accepted when high with wr_valid.
- wr_x  input  16  write column.
- wr_y  input  16  write row.
- wr_data  input  DATA_WIDTH  write pixel.
- fifo_level  output  $clog2(WR_FIFO_DEPTH+1)  entries queued.
- wr_clip  output  1  pulse, write discarded as off-screen.
- mem_addr  output  ADDR_WIDTH  frame buffer address.
- mem_we  output  1  write strobe.
- mem_wdata  output  DATA_WIDTH  write data.
- mem_rdata  input  DATA_WIDTH  read data.

Interface note: one clock; reset is asynchronous and active-low (clock port named clock, reset port named reset_n).

Behaviour:
- Reset values:
  - mem_addr=0, mem_we=0, mem_wdata=0.
  - disp_valid=0, disp_data=0, wr_clip=0.
  - fifo_level=0, so wr_ready=1 once reset is released.
- Reset asserted mid-operation: FIFO is emptied, in-flight reads are discarded, and no disp_valid is produced for them.
- Address: addr = y*SCREEN_WIDTH + x, computed at full precision and truncated to ADDR_WIDTH.
- Display fetch is "in range" when disp_x<SCREEN_WIDTH and disp_y<SCREEN_HEIGHT.
- Arbitration, evaluated every cycle (cycle t):
  - disp_req=1 and in range: display owns the port. At t+1, mem_addr = display address and mem_we=0.
  - disp_req=1 and out of range: port is not used by the display, and the FIFO head may write this cycle. A blank pixel (disp_data=0) is still returned with normal latency.
  - disp_req=0: FIFO head, if present, pops. At t+1, mem_addr/mem_wdata come from the head and mem_we=1.
  - No winner: at t+1, mem_we=0 and mem_addr holds its previous value.
- Memory outputs are registered; there is no combinational path from inputs to mem_*.
- Read return:
  - Every disp_req produces exactly one disp_valid, exactly 1+MEM_LATENCY cycles later (default 2). Order is preserved.
  - disp_data = mem_rdata for in-range fetches, 0 for out-of-range fetches.
  - This is a shift-register valid/blank-flag pipeline of depth 1+MEM_LATENCY.
  - Back-to-back requests every cycle are supported.
- Write FIFO:
  - wr_ready = (fifo_level != WR_FIFO_DEPTH).
  - Push occurs on wr_valid && wr_ready.
  - When full, wr_ready=0 even if a pop occurs the same cycle; there is no full bypass.
  - Push and pop in the same cycle when not full: level unchanged.
  - An entry pushed into an empty FIFO at cycle t can pop no earlier than t+1; there is no empty bypass.
  - Pointers wrap modulo WR_FIFO_DEPTH.
- Writes may starve indefinitely under continuous in-range display fetch. This is by design, because the display fetches only in the active region and blanking guarantees drain slots.
- Read/write hazard: a write to an address fetched in the same cycle is not reordered. The display sees the old data if its fetch wins first.

Optional Feature:
- Macro: DRAW_CLIP_EN.
- Defined:
  - A write with wr_x>=SCREEN_WIDTH or wr_y>=SCREEN_HEIGHT is accepted (wr_ready honored) but never enters the FIFO.
  - wr_clip pulses high for 1 cycle, the cycle after acceptance.
- Undefined:
  - All accepted writes are queued and use the truncated address.
  - wr_clip is tied 0.

Test Plan:
- Reset, then idle 5 cycles -> wr_ready=1, fifo_level=0, mem_we=0, disp_valid=0 throughout.
- disp_req=1 with (x=3,y=2), mem returns 16'hABCD -> mem_addr=1603 at t+1; disp_valid=1 with disp_data=16'hABCD at t+2; single pulse.
- disp_req held high 10 cycles at in-range positions while offering 6 writes -> wr_ready drops after 4 accepted, mem_we stays 0 for the 10 cycles, fifo_level=4. After disp_req drops: 4 consecutive mem_we pulses in push order, then the remaining 2 writes accepted and drained.
- disp_req=1 with (x=800,y=0) while FIFO holds 1 write -> mem_we=1 at t+1 with the write's address; disp_valid=1 with disp_data=0 at t+2.
- Async reset asserted mid-cycle with FIFO at 3 and 2 reads in flight -> outputs are at reset values immediately; no disp_valid after release; fifo_level=0.
- DRAW_CLIP_EN defined, write (x=10,y=480) -> accepted, wr_clip pulses once, fifo_level stays 0, no mem_we. Undefined: queued and written at address (480*800+10) mod 2^19.

Source files
------------

// File: rtl/frame_buffer_arbiter_if.sv
// Frame buffer arbiter bus: display fetch, draw writes and memory port.
// Optional DRAW_CLIP_EN only changes how the arbiter drives wr_clip.
interface frame_buffer_arbiter_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 19,
    parameter int WR_FIFO_DEPTH = 4
);
    localparam int LEVEL_WIDTH = $clog2(WR_FIFO_DEPTH + 1);

    logic                   disp_req;
    logic [15:0]            disp_x;
    logic [15:0]            disp_y;
    logic                   disp_valid;
    logic [DATA_WIDTH-1:0]  disp_data;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [15:0]            wr_x;
    logic [15:0]            wr_y;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic [LEVEL_WIDTH-1:0] fifo_level;
    logic                   wr_clip;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic                   mem_we;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    logic [DATA_WIDTH-1:0]  mem_rdata;

    modport master (
        output disp_req, disp_x, disp_y,
        input  disp_valid, disp_data,
        output wr_valid, wr_x, wr_y, wr_data,
        input  wr_ready, fifo_level, wr_clip,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  disp_req, disp_x, disp_y,
        output disp_valid, disp_data,
        input  wr_valid, wr_x, wr_y, wr_data,
        output wr_ready, fifo_level, wr_clip,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Single-port frame buffer arbiter: display fetch wins, draw writes queue.
// Define DRAW_CLIP_EN to drop off-screen writes and pulse wr_clip.
module frame_buffer_arbiter #(
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 480,
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 19,
    parameter int WR_FIFO_DEPTH = 4,
    parameter int MEM_LATENCY   = 1
) (
    input logic clock,
    input logic reset_n,
    frame_buffer_arbiter_if.slave bus
);
    localparam int LW   = $clog2(WR_FIFO_DEPTH + 1);
    localparam int PW   = $clog2(WR_FIFO_DEPTH);
    localparam int PIPE = 1 + MEM_LATENCY;

    function automatic logic [ADDR_WIDTH-1:0] to_addr(
        input logic [15:0] x,
        input logic [15:0] y
    );
        return ADDR_WIDTH'({16'd0, y} * 32'(SCREEN_WIDTH)
                           + {16'd0, x});
    endfunction

    logic [ADDR_WIDTH-1:0] fifo_addr [WR_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [WR_FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level;
    logic [PIPE-1:0]       rd_vld;
    logic [PIPE-1:0]       rd_inr;

    logic disp_in_range;
    logic disp_win;
    logic accept;
    logic push;
    logic pop;

    assign disp_in_range = (bus.disp_x < 16'(SCREEN_WIDTH))
                        && (bus.disp_y < 16'(SCREEN_HEIGHT));
    assign disp_win = bus.disp_req && disp_in_range;
    assign pop      = !disp_win && (level != '0);

    assign bus.wr_ready   = (level != LW'(WR_FIFO_DEPTH));
    assign bus.fifo_level = level;
    assign accept         = bus.wr_valid && bus.wr_ready;

`ifdef DRAW_CLIP_EN
    logic wr_off;
    logic clip_q;

    assign wr_off = (bus.wr_x >= 16'(SCREEN_WIDTH))
                 || (bus.wr_y >= 16'(SCREEN_HEIGHT));
    assign push   = accept && !wr_off;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) clip_q <= 1'b0;
        else          clip_q <= accept && wr_off;
    end

    assign bus.wr_clip = clip_q;
`else
    assign push        = accept;
    assign bus.wr_clip = 1'b0;
`endif

    // Storage needs no reset; validity is tracked by level and pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= to_addr(bus.wr_x, bus.wr_y);
            fifo_data[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.mem_addr  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_wdata <= '0;
        end else if (disp_win) begin
            bus.mem_addr  <= to_addr(bus.disp_x, bus.disp_y);
            bus.mem_we    <= 1'b0;
        end else if (pop) begin
            bus.mem_addr  <= fifo_addr[rd_ptr];
            bus.mem_wdata <= fifo_data[rd_ptr];
            bus.mem_we    <= 1'b1;
        end else begin
            bus.mem_we    <= 1'b0;
        end
    end

    // Tail of the pipe lines up with mem_rdata for the matching fetch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld <= '0;
            rd_inr <= '0;
        end else begin
            rd_vld <= {rd_vld[PIPE-2:0], bus.disp_req};
            rd_inr <= {rd_inr[PIPE-2:0], disp_win};
        end
    end

    assign bus.disp_valid = rd_vld[PIPE-1];
    assign bus.disp_data  = (rd_vld[PIPE-1] && rd_inr[PIPE-1])
                          ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter.
// Build with or without DRAW_CLIP_EN; the clip scenario follows the macro.
module tb_frame_buffer_arbiter;
    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    frame_buffer_arbiter_if #(
        .DATA_WIDTH(16), .ADDR_WIDTH(19), .WR_FIFO_DEPTH(4)
    ) bus ();

    frame_buffer_arbiter #(
        .SCREEN_WIDTH(800), .SCREEN_HEIGHT(480), .DATA_WIDTH(16),
        .ADDR_WIDTH(19), .WR_FIFO_DEPTH(4), .MEM_LATENCY(1)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, time %0t limit 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.disp_req  = 1'b0;
        bus.disp_x    = '0;
        bus.disp_y    = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_x      = '0;
        bus.wr_y      = '0;
        bus.wr_data   = '0;
        bus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #4;
        checks++;
        if (bus.mem_addr !== 19'd0 || bus.mem_we !== 1'b0
            || bus.mem_wdata !== 16'd0) begin
            errors++;
            $display("FAIL reset_mem: addr %0d we %b wdata %h, want 0 0 0",
                     bus.mem_addr, bus.mem_we, bus.mem_wdata);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.wr_ready !== 1'b1 || bus.fifo_level !== 3'd0
                || bus.mem_we !== 1'b0 || bus.disp_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_%0d: ready %b level %0d we %b dv %b, want 1 0 0 0",
                         i, bus.wr_ready, bus.fifo_level, bus.mem_we,
                         bus.disp_valid);
            end
        end
    endtask

    task automatic test_single_fetch();
        bus.disp_req  = 1'b1;
        bus.disp_x    = 16'd3;
        bus.disp_y    = 16'd2;
        bus.mem_rdata = 16'hABCD;
        step();
        bus.disp_req = 1'b0;
        checks++;
        if (bus.mem_addr !== 19'd1603 || bus.mem_we !== 1'b0
            || bus.disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_addr: addr %0d we %b dv %b, want 1603 0 0",
                     bus.mem_addr, bus.mem_we, bus.disp_valid);
        end
        step();
        checks++;
        if (bus.disp_valid !== 1'b1 || bus.disp_data !== 16'hABCD) begin
            errors++;
            $display("FAIL fetch_data: dv %b data %h, want 1 abcd",
                     bus.disp_valid, bus.disp_data);
        end
        step();
        checks++;
        if (bus.disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_pulse: dv %b, want 0", bus.disp_valid);
        end
    endtask

    task automatic test_starve_and_drain();
        int sent;
        logic acc;
        sent = 0;
        bus.mem_rdata = 16'h0;
        for (int c = 0; c < 10; c++) begin
            bus.disp_req = 1'b1;
            bus.disp_x   = 16'(c * 7);
            bus.disp_y   = 16'(c);
            bus.wr_valid = (sent < 6);
            bus.wr_x     = 16'(sent + 1);
            bus.wr_y     = 16'd1;
            bus.wr_data  = 16'(16'h1000 + sent);
            acc = bus.wr_valid && bus.wr_ready;
            step();
            if (acc) sent++;
            checks++;
            if (bus.mem_we !== 1'b0) begin
                errors++;
                $display("FAIL starve_we_%0d: we %b, want 0", c, bus.mem_we);
            end
        end
        checks++;
        if (bus.fifo_level !== 3'd4 || bus.wr_ready !== 1'b0 || sent != 4) begin
            errors++;
            $display("FAIL starve_full: level %0d ready %b accepted %0d, want 4 0 4",
                     bus.fifo_level, bus.wr_ready, sent);
        end
        bus.disp_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.wr_valid = (sent < 6);
            bus.wr_x     = 16'(sent + 1);
            bus.wr_y     = 16'd1;
            bus.wr_data  = 16'(16'h1000 + sent);
            acc = bus.wr_valid && bus.wr_ready;
            step();
            if (acc) sent++;
            checks++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 19'(801 + k)
                || bus.mem_wdata !== 16'(16'h1000 + k)) begin
                errors++;
                $display("FAIL drain_%0d: we %b addr %0d data %h, want 1 %0d %h",
                         k, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                         801 + k, 16'h1000 + k);
            end
        end
        bus.wr_valid = 1'b0;
        step();
        checks++;
        if (bus.mem_we !== 1'b0 || bus.fifo_level !== 3'd0 || sent != 6) begin
            errors++;
            $display("FAIL drain_done: we %b level %0d accepted %0d, want 0 0 6",
                     bus.mem_we, bus.fifo_level, sent);
        end
    endtask

    task automatic test_out_of_range();
        bus.mem_rdata = 16'hFFFF;
        bus.disp_req  = 1'b1;
        bus.disp_x    = 16'd0;
        bus.disp_y    = 16'd0;
        bus.wr_valid  = 1'b1;
        bus.wr_x      = 16'd5;
        bus.wr_y      = 16'd3;
        bus.wr_data   = 16'h5555;
        step();
        bus.wr_valid = 1'b0;
        bus.disp_x   = 16'd800;
        bus.disp_y   = 16'd0;
        checks++;
        if (bus.fifo_level !== 3'd1 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL oor_held: level %0d we %b, want 1 0",
                     bus.fifo_level, bus.mem_we);
        end
        step();
        bus.disp_req = 1'b0;
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 19'd2405
            || bus.mem_wdata !== 16'h5555) begin
            errors++;
            $display("FAIL oor_write: we %b addr %0d data %h, want 1 2405 5555",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (bus.disp_valid !== 1'b1 || bus.disp_data !== 16'hFFFF) begin
            errors++;
            $display("FAIL oor_prev_read: dv %b data %h, want 1 ffff",
                     bus.disp_valid, bus.disp_data);
        end
        step();
        checks++;
        if (bus.disp_valid !== 1'b1 || bus.disp_data !== 16'h0000) begin
            errors++;
            $display("FAIL oor_blank: dv %b data %h, want 1 0000",
                     bus.disp_valid, bus.disp_data);
        end
        step();
        checks++;
        if (bus.disp_valid !== 1'b0 || bus.fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL oor_end: dv %b level %0d, want 0 0",
                     bus.disp_valid, bus.fifo_level);
        end
        bus.mem_rdata = 16'h0;
    endtask

    task automatic test_async_reset();
        bus.disp_req = 1'b1;
        bus.disp_x   = 16'd1;
        bus.disp_y   = 16'd1;
        bus.mem_rdata = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_x     = 16'(20 + i);
            bus.wr_y     = 16'd2;
            bus.wr_data  = 16'(16'h2000 + i);
            step();
        end
        bus.wr_valid = 1'b0;
        checks++;
        if (bus.fifo_level !== 3'd3) begin
            errors++;
            $display("FAIL areset_pre: level %0d, want 3", bus.fifo_level);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.fifo_level !== 3'd0 || bus.disp_valid !== 1'b0
            || bus.disp_data !== 16'd0 || bus.mem_addr !== 19'd0
            || bus.mem_we !== 1'b0 || bus.wr_clip !== 1'b0) begin
            errors++;
            $display("FAIL areset_now: level %0d dv %b data %h addr %0d we %b clip %b, want 0 0 0 0 0 0",
                     bus.fifo_level, bus.disp_valid, bus.disp_data,
                     bus.mem_addr, bus.mem_we, bus.wr_clip);
        end
        bus.disp_req = 1'b0;
        step();
        #3;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.disp_valid !== 1'b0 || bus.mem_we !== 1'b0
                || bus.fifo_level !== 3'd0 || bus.wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL areset_after_%0d: dv %b we %b level %0d ready %b, want 0 0 0 1",
                         i, bus.disp_valid, bus.mem_we, bus.fifo_level,
                         bus.wr_ready);
            end
        end
        bus.mem_rdata = 16'h0;
    endtask

    task automatic test_clip();
        bus.wr_valid = 1'b1;
        bus.wr_x     = 16'd10;
        bus.wr_y     = 16'd480;
        bus.wr_data  = 16'h3C3C;
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL clip_ready: ready %b, want 1", bus.wr_ready);
        end
        step();
        bus.wr_valid = 1'b0;
`ifdef DRAW_CLIP_EN
        checks++;
        if (bus.wr_clip !== 1'b1 || bus.fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL clip_pulse: clip %b level %0d, want 1 0",
                     bus.wr_clip, bus.fifo_level);
        end
        step();
        checks++;
        if (bus.wr_clip !== 1'b0 || bus.mem_we !== 1'b0
            || bus.fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL clip_after: clip %b we %b level %0d, want 0 0 0",
                     bus.wr_clip, bus.mem_we, bus.fifo_level);
        end
`else
        checks++;
        if (bus.wr_clip !== 1'b0 || bus.fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL noclip_queue: clip %b level %0d, want 0 1",
                     bus.wr_clip, bus.fifo_level);
        end
        step();
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 19'd384010
            || bus.mem_wdata !== 16'h3C3C) begin
            errors++;
            $display("FAIL noclip_write: we %b addr %0d data %h, want 1 384010 3c3c",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
`endif
        step();
        checks++;
        if (bus.mem_we !== 1'b0 || bus.wr_clip !== 1'b0) begin
            errors++;
            $display("FAIL clip_end: we %b clip %b, want 0 0",
                     bus.mem_we, bus.wr_clip);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_fetch();
        test_starve_and_drain();
        test_out_of_range();
        test_async_reset();
        test_clip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
